// File: rtl/aes_link_ctrl.sv
// aes_link_ctrl -- multi-channel link controller for the Alice/Bob AES pair.
//
// Buffers 128-bit blocks from CHANNELS user ports in per-channel FIFOs,
// arbitrates round-robin, and hands one block at a time to the Alice
// encryptor when both endpoints are ready. It also aggregates the long-key
// status and sequences the long-key change handshake.
//
// Build option: define AES_LINK_PRIO_EN to make channel 0 strict priority
// (round-robin then applies only among channels 1..CHANNELS-1).
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   ch_stb/ch_data               per-channel write strobe and block
//   ch_full/ch_ovf               per-channel FIFO full, sticky overflow
//   link_ready_a/link_ready_b    ready_for_transmit from alice/bob
//   transmit_req                 registered transmit request
//   link_stb/link_data/link_ch   one-cycle block strobe, block, channel tag
//   link_done                    bob delivered the block
//   key_valid_a/b, key_rq_a/b    long-key status and change requests
//   key_ch                       one-cycle long-key change command
//   key_valid                    registered AND of both key_valid inputs
//   err_timeout                  sticky: a transfer aborted on timeout

// Per-channel block FIFO. Overflowing writes are dropped and flagged.
module aes_link_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_stb,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full,
  output logic              ovf
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, full_d, ovf_q, ovf_d;
  logic              push;

  // A full FIFO still accepts a write in the cycle it is popped.
  always_comb begin
    push     = push_stb & (~full_q | pop);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (cnt_d == CNT_W'(DEPTH));
    ovf_d    = ovf_q | (push_stb & ~push);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = full_q;
  assign ovf   = ovf_q;
endmodule

module aes_link_ctrl #(
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 128,
  parameter int TIMEOUT  = 1024,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        ch_stb,
  input  logic [CHANNELS*DATA_W-1:0] ch_data,
  output logic [CHANNELS-1:0]        ch_full,
  output logic [CHANNELS-1:0]        ch_ovf,
  input  logic                       link_ready_a,
  input  logic                       link_ready_b,
  output logic                       transmit_req,
  output logic                       link_stb,
  output logic [DATA_W-1:0]          link_data,
  output logic [CH_W-1:0]            link_ch,
  input  logic                       link_done,
  input  logic                       key_valid_a,
  input  logic                       key_valid_b,
  input  logic                       key_rq_a,
  input  logic                       key_rq_b,
  output logic                       key_ch,
  output logic                       key_valid,
  output logic                       err_timeout
);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
`ifdef AES_LINK_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_KEY_CH, S_KEY_WAIT} state_e;

  state_e                            state_q;
  logic [CH_W-1:0]                   last_grant_q;
  logic [TMR_W-1:0]                  timer_q;
  logic                              link_stb_q, key_ch_q, key_valid_q;
  logic                              transmit_req_q, err_timeout_q;
  logic [DATA_W-1:0]                 link_data_q;
  logic [CH_W-1:0]                   link_ch_q;

  logic [CHANNELS-1:0][DATA_W-1:0]   heads;
  logic [CHANNELS-1:0]               empty, pop;
  logic                              gnt_found, grant_fire;
  logic [CH_W-1:0]                   gnt_idx, cand_idx;
  int                                cand;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    aes_link_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push_stb  (ch_stb[i]),
      .push_data (ch_data[i*DATA_W +: DATA_W]),
      .pop       (pop[i]),
      .head      (heads[i]),
      .empty     (empty[i]),
      .full      (ch_full[i]),
      .ovf       (ch_ovf[i])
    );
  end

  // Round-robin scan starting just after the last grant. In priority mode
  // channel 0 is skipped by the scan and overrides it when non-empty.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= CHANNELS; off++) begin
      cand     = (int'(last_grant_q) + off) % CHANNELS;
      cand_idx = CH_W'(cand);
      if (!gnt_found && !empty[cand_idx] && !(PRIO_EN && cand == 0)) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    if (PRIO_EN && !empty[0]) begin
      gnt_found = 1'b1;
      gnt_idx   = '0;
    end
  end

  // Key change requests win over data in IDLE.
  assign grant_fire = (state_q == S_IDLE) && !(key_rq_a && key_rq_b) && gnt_found &&
                      key_valid_q && link_ready_a && link_ready_b;

  always_comb begin
    pop = '0;
    if (grant_fire) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      last_grant_q   <= CH_W'(CHANNELS - 1);
      timer_q        <= '0;
      link_stb_q     <= 1'b0;
      link_data_q    <= '0;
      link_ch_q      <= '0;
      key_ch_q       <= 1'b0;
      key_valid_q    <= 1'b0;
      transmit_req_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      link_stb_q     <= 1'b0;
      key_ch_q       <= 1'b0;
      key_valid_q    <= key_valid_a & key_valid_b;
      transmit_req_q <= link_ready_a & link_ready_b & (state_q == S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (key_rq_a && key_rq_b) begin
            state_q  <= S_KEY_CH;
            key_ch_q <= 1'b1;
          end else if (grant_fire) begin
            link_stb_q  <= 1'b1;
            link_data_q <= heads[gnt_idx];
            link_ch_q   <= gnt_idx;
            timer_q     <= '0;
            state_q     <= S_WAIT;
            // Priority grants of channel 0 leave the rotation untouched so
            // channels 1..N-1 stay fair among themselves.
            if (!PRIO_EN || gnt_idx != '0) last_grant_q <= gnt_idx;
          end
        end
        S_WAIT: begin
          if (link_done) begin
            state_q <= S_IDLE;
          end else if (timer_q == TMR_LAST) begin
            err_timeout_q <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_KEY_CH:   state_q <= S_KEY_WAIT;
        S_KEY_WAIT: if (key_valid_a && key_valid_b) state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  assign transmit_req = transmit_req_q;
  assign link_stb     = link_stb_q;
  assign link_data    = link_data_q;
  assign link_ch      = link_ch_q;
  assign key_ch       = key_ch_q;
  assign key_valid    = key_valid_q;
  assign err_timeout  = err_timeout_q;
endmodule

// File: tb/tb_aes_link_ctrl.sv
// Directed bench for aes_link_ctrl: CHANNELS=4, DEPTH=4, TIMEOUT=16.
module tb_aes_link_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   ch_stb;
  logic [511:0] ch_data;
  logic [3:0]   ch_full, ch_ovf;
  logic         link_ready_a, link_ready_b, transmit_req, link_stb, link_done;
  logic [127:0] link_data;
  logic [1:0]   link_ch;
  logic         key_valid_a, key_valid_b, key_rq_a, key_rq_b, key_ch, key_valid, err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  aes_link_ctrl #(.CHANNELS(4), .DEPTH(4), .DATA_W(128), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ch_stb(ch_stb), .ch_data(ch_data),
    .ch_full(ch_full), .ch_ovf(ch_ovf),
    .link_ready_a(link_ready_a), .link_ready_b(link_ready_b),
    .transmit_req(transmit_req), .link_stb(link_stb), .link_data(link_data),
    .link_ch(link_ch), .link_done(link_done),
    .key_valid_a(key_valid_a), .key_valid_b(key_valid_b),
    .key_rq_a(key_rq_a), .key_rq_b(key_rq_b),
    .key_ch(key_ch), .key_valid(key_valid), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] blk(input logic [31:0] t);
    return {4{t}};
  endfunction

  task automatic put(input int ch, input logic [127:0] d);
    ch_data[ch*128 +: 128] = d;
  endtask

  // Waits (bounded) for link_stb, then checks tag and data.
  task automatic wait_grant(input string tag, input int exp_ch, input logic [127:0] exp_d);
    int n = 0;
    while (link_stb !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_stb"}, 128'(link_stb), 128'd1);
    chk({tag, "_ch"}, 128'(link_ch), 128'(exp_ch));
    chk({tag, "_data"}, link_data, exp_d);
  endtask

  // link_done two cycles after link_stb.
  task automatic finish_xfer();
    step();
    step();
    link_done = 1'b1;
    step();
    link_done = 1'b0;
  endtask

  task automatic no_stb(input string tag, input int cycles);
    int cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (link_stb === 1'b1) cnt++;
      step();
    end
    chk(tag, 128'(cnt), 128'd0);
  endtask

  initial begin
    reset = 1'b1; ch_stb = '0; ch_data = '0; link_done = 1'b0;
    link_ready_a = 1'b0; link_ready_b = 1'b0;
    key_valid_a = 1'b0; key_valid_b = 1'b0; key_rq_a = 1'b0; key_rq_b = 1'b0;
    step(); step(); step();
    chk("rst_full", 128'(ch_full), 128'd0);
    chk("rst_ovf", 128'(ch_ovf), 128'd0);
    chk("rst_stb", 128'(link_stb), 128'd0);
    chk("rst_data", link_data, 128'd0);
    chk("rst_treq", 128'(transmit_req), 128'd0);
    chk("rst_keych", 128'(key_ch), 128'd0);
    chk("rst_kvalid", 128'(key_valid), 128'd0);
    chk("rst_err", 128'(err_timeout), 128'd0);

    // Single block on channel 2, t+2 latency
    reset = 1'b0; link_ready_a = 1'b1; link_ready_b = 1'b1;
    key_valid_a = 1'b1; key_valid_b = 1'b1;
    step(); step();
    chk("kvalid_up", 128'(key_valid), 128'd1);
    chk("treq_idle", 128'(transmit_req), 128'd1);
    put(2, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    ch_stb = 4'b0100;
    step();
    ch_stb = '0;
    chk("single_t1_stb", 128'(link_stb), 128'd0);
    step();
    chk("single_t2_stb", 128'(link_stb), 128'd1);
    chk("single_ch", 128'(link_ch), 128'd2);
    chk("single_data", link_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    step();
    chk("single_stb_pulse", 128'(link_stb), 128'd0);
    chk("single_treq_wait", 128'(transmit_req), 128'd0);
    link_done = 1'b1;
    step();
    link_done = 1'b0;
    step();
    chk("single_treq_back", 128'(transmit_req), 128'd1);
    chk("single_hold_ch", 128'(link_ch), 128'd2);

    // Round-robin 0,1,2,3 then 0,2,3 from a fresh reset
    reset = 1'b1;
    step();
    chk("rst2_data", link_data, 128'd0);
    reset = 1'b0;
    step(); step();
    for (int i = 0; i < 4; i++) put(i, blk(32'hD000_0000 + i));
    ch_stb = 4'hF;
    step();
    ch_stb = '0;
    for (int i = 0; i < 4; i++) begin
      wait_grant($sformatf("rr%0d", i), i, blk(32'hD000_0000 + i));
      finish_xfer();
    end
    for (int i = 0; i < 4; i++) put(i, blk(32'hE000_0000 + i));
    ch_stb = 4'b1101;
    step();
    ch_stb = '0;
    wait_grant("rrb0", 0, blk(32'hE000_0000)); finish_xfer();
    wait_grant("rrb2", 2, blk(32'hE000_0002)); finish_xfer();
    wait_grant("rrb3", 3, blk(32'hE000_0003)); finish_xfer();

    // Overflow on channel 3, then push+pop while full
    link_ready_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      put(3, blk(32'hA000_0000 + i));
      ch_stb = 4'b1000;
      step();
      if (i == 2) chk("ovf_full_3rd", 128'(ch_full[3]), 128'd0);
      if (i == 3) begin
        chk("ovf_full_4th", 128'(ch_full[3]), 128'd1);
        chk("ovf_clear_4th", 128'(ch_ovf[3]), 128'd0);
      end
    end
    chk("ovf_set_5th", 128'(ch_ovf), 128'h8);
    chk("ovf_treq_low", 128'(transmit_req), 128'd0);
    put(3, blk(32'hA000_0005));
    link_ready_a = 1'b1;
    step();
    ch_stb = '0;
    chk("pushpop_full", 128'(ch_full[3]), 128'd1);
    chk("pushpop_noovf", 128'(ch_ovf), 128'h8);
    wait_grant("ovf_o0", 3, blk(32'hA000_0000)); finish_xfer();
    wait_grant("ovf_o1", 3, blk(32'hA000_0001)); finish_xfer();
    wait_grant("ovf_o2", 3, blk(32'hA000_0002)); finish_xfer();
    wait_grant("ovf_o3", 3, blk(32'hA000_0003)); finish_xfer();
    wait_grant("ovf_o5", 3, blk(32'hA000_0005)); finish_xfer();
    chk("ovf_drained", 128'(ch_full), 128'd0);
    no_stb("ovf_no_extra", 8);

    // Key change requested mid-transfer
    put(0, blk(32'hB000_0000));
    ch_stb = 4'b0001;
    step();
    ch_stb = '0;
    wait_grant("key_k0", 0, blk(32'hB000_0000));
    key_rq_a = 1'b1; key_rq_b = 1'b1;
    step();
    chk("key_wait1", 128'(key_ch), 128'd0);
    step();
    chk("key_wait2", 128'(key_ch), 128'd0);
    link_done = 1'b1;
    step();
    link_done = 1'b0;
    chk("key_idle", 128'(key_ch), 128'd0);
    step();
    chk("key_ch_pulse", 128'(key_ch), 128'd1);
    key_rq_a = 1'b0; key_rq_b = 1'b0; key_valid_b = 1'b0;
    put(1, blk(32'hB000_0001));
    ch_stb = 4'b0010;
    step();
    ch_stb = '0;
    chk("key_ch_one", 128'(key_ch), 128'd0);
    chk("key_valid_low", 128'(key_valid), 128'd0);
    no_stb("key_hold", 10);
    key_valid_b = 1'b1;
    wait_grant("key_k1", 1, blk(32'hB000_0001));
    finish_xfer();

    // Timeout with a second block queued
    put(2, blk(32'hC000_0002));
    put(3, blk(32'hC000_0003));
    ch_stb = 4'b1100;
    step();
    ch_stb = '0;
    wait_grant("to_t0", 2, blk(32'hC000_0002));
    for (int i = 0; i < 15; i++) step();
    chk("to_before", 128'(err_timeout), 128'd0);
    step();
    chk("to_set", 128'(err_timeout), 128'd1);
    step();
    chk("to_next_stb", 128'(link_stb), 128'd1);
    chk("to_next_ch", 128'(link_ch), 128'd3);
    chk("to_next_data", link_data, blk(32'hC000_0003));
    finish_xfer();
    chk("to_sticky", 128'(err_timeout), 128'd1);

    // Channels 0 and 1 both loaded with two blocks
    put(0, blk(32'hF000_0000)); put(1, blk(32'hF100_0000));
    ch_stb = 4'b0011;
    step();
    put(0, blk(32'hF000_0001)); put(1, blk(32'hF100_0001));
    step();
    ch_stb = '0;
`ifdef AES_LINK_PRIO_EN
    wait_grant("pr_a0", 0, blk(32'hF000_0000)); finish_xfer();
    wait_grant("pr_a1", 0, blk(32'hF000_0001)); finish_xfer();
    wait_grant("pr_b0", 1, blk(32'hF100_0000)); finish_xfer();
    wait_grant("pr_b1", 1, blk(32'hF100_0001)); finish_xfer();
`else
    wait_grant("alt_a0", 0, blk(32'hF000_0000)); finish_xfer();
    wait_grant("alt_b0", 1, blk(32'hF100_0000)); finish_xfer();
    wait_grant("alt_a1", 0, blk(32'hF000_0001)); finish_xfer();
    wait_grant("alt_b1", 1, blk(32'hF100_0001)); finish_xfer();
`endif

    // Reset mid-transfer discards buffered blocks
    put(0, blk(32'h9000_0000)); put(1, blk(32'h9100_0000));
    ch_stb = 4'b0011;
    step();
    ch_stb = '0;
    wait_grant("mid_r0", 0, blk(32'h9000_0000));
    step();
    reset = 1'b1;
    step();
    chk("mid_stb", 128'(link_stb), 128'd0);
    chk("mid_ovf", 128'(ch_ovf), 128'd0);
    chk("mid_err", 128'(err_timeout), 128'd0);
    chk("mid_ch", 128'(link_ch), 128'd0);
    reset = 1'b0;
    no_stb("mid_discard", 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
